// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared types and constants for the boot-time ROM loader.
//   state_e            - loader FSM states (FETCH, WRITE, DONE)
//   DEFAULT_WORD_BYTES - default number of ROM bytes packed per RAM word
//   lane_width()       - lane index width for a given word size, minimum 1 bit
//   LANE_W             - lane index width for the default word size
package rom_loader_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WORD_BYTES = 4;

  // A one-byte word still needs a 1-bit lane counter to keep the types legal.
  function automatic int lane_width(input int word_bytes);
    return (word_bytes > 1) ? $clog2(word_bytes) : 1;
  endfunction

  localparam int LANE_W = lane_width(DEFAULT_WORD_BYTES);

endpackage

// File: rtl/rom_loader_word_packer.sv
// rom_loader_word_packer: assembles ROM bytes little-endian into one RAM word.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   capture     - store byte_in into the current lane and mark it enabled
//   advance     - move to the next lane after this capture
//   clear       - empty the word and restart at lane 0 (wins over capture)
//   byte_in     - ROM byte to store
//   lane_last   - current lane is the top lane of the word
//   data        - packed word, lane i in bits [8*i +: 8]
//   byte_en     - one bit per lane that holds a captured byte
module rom_loader_word_packer
  import rom_loader_pkg::*;
#(
  parameter int WORD_BYTES = DEFAULT_WORD_BYTES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    capture,
  input  logic                    advance,
  input  logic                    clear,
  input  logic [7:0]              byte_in,
  output logic                    lane_last,
  output logic [8*WORD_BYTES-1:0] data,
  output logic [WORD_BYTES-1:0]   byte_en
);

  localparam int LANE_W_LOCAL = lane_width(WORD_BYTES);

  logic [LANE_W_LOCAL-1:0] lane_q, lane_d;
  logic [8*WORD_BYTES-1:0] buf_q, buf_d;
  logic [WORD_BYTES-1:0]   be_q, be_d;

  assign lane_last = (lane_q == LANE_W_LOCAL'(WORD_BYTES - 1));
  assign data      = buf_q;
  assign byte_en   = be_q;

  always_comb begin
    lane_d = lane_q;
    buf_d  = buf_q;
    be_d   = be_q;
    if (clear) begin
      lane_d = '0;
      buf_d  = '0;
      be_d   = '0;
    end else if (capture) begin
      // Lane decode by comparison keeps the 1-byte configuration index-safe.
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (lane_q == LANE_W_LOCAL'(i)) begin
          buf_d[i*8 +: 8] = byte_in;
          be_d[i]         = 1'b1;
        end
      end
      if (advance) begin
        lane_d = lane_q + LANE_W_LOCAL'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      buf_q  <= '0;
      be_q   <= '0;
    end else begin
      lane_q <= lane_d;
      buf_q  <= buf_d;
      be_q   <= be_d;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: copies the program ROM into main RAM after reset, then releases
// the CPU. ROM bytes are read one per cycle from address 0, packed into
// WORD_BYTES-wide words and written over a valid/ready port.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   rom_address         - byte address presented to the ROM
//   rom_byte, rom_done  - combinational ROM data and last-byte flag
//   mem_valid/mem_ready - RAM write handshake
//   mem_addr            - RAM byte address of the word (WORD_BYTES aligned)
//   mem_wdata           - packed word, lane i = ROM byte word_index*WORD_BYTES+i
//   mem_byte_en         - lanes carrying real ROM bytes
//   cpu_reset_n         - CPU reset, released once the load is complete
//   load_done           - sticky completion flag
//   load_error          - sticky: MAX_BYTES reached without rom_done
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int                        WORD_BYTES     = DEFAULT_WORD_BYTES,
  parameter int                        MEM_ADDR_WIDTH = 32,
  parameter logic [MEM_ADDR_WIDTH-1:0] MEM_BASE       = '0,
  parameter int                        MAX_BYTES      = 65536
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [31:0]               rom_address,
  input  logic [7:0]                rom_byte,
  input  logic                      rom_done,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [8*WORD_BYTES-1:0]   mem_wdata,
  output logic [WORD_BYTES-1:0]     mem_byte_en,
  output logic                      cpu_reset_n,
  output logic                      load_done,
  output logic                      load_error
);

  localparam logic [31:0]               GUARD_ADDR = 32'(MAX_BYTES - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_STEP  = MEM_ADDR_WIDTH'(WORD_BYTES);

  state_e                    state_q, state_d;
  logic [31:0]               rom_address_q, rom_address_d;
  logic                      mem_valid_q, mem_valid_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                      last_q, last_d;
  logic                      load_done_q, load_done_d;
  logic                      load_error_q, load_error_d;
  logic                      cpu_reset_n_q, cpu_reset_n_d;

  logic guard_hit;
  logic fetch_last;
  logic word_end;
  logic handshake;
  logic pk_capture;
  logic pk_advance;
  logic pk_clear;
  logic pk_lane_last;

  assign guard_hit  = (rom_address_q == GUARD_ADDR);
  assign fetch_last = rom_done | guard_hit;
  assign word_end   = fetch_last | pk_lane_last;
  // mem_valid is high for the whole of WRITE, so ready alone completes it.
  assign handshake  = (state_q == ST_WRITE) && mem_ready;

  assign pk_capture = (state_q == ST_FETCH);
  assign pk_advance = pk_capture && !word_end;
  assign pk_clear   = handshake && !last_q;

  rom_loader_word_packer #(
    .WORD_BYTES(WORD_BYTES)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (pk_capture),
    .advance  (pk_advance),
    .clear    (pk_clear),
    .byte_in  (rom_byte),
    .lane_last(pk_lane_last),
    .data     (mem_wdata),
    .byte_en  (mem_byte_en)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (word_end)  state_d = ST_WRITE;
      ST_WRITE: if (mem_ready) state_d = last_q ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_FETCH;
    endcase
  end

  // Output and address logic
  always_comb begin
    rom_address_d = rom_address_q;
    mem_valid_d   = mem_valid_q;
    mem_addr_d    = mem_addr_q;
    last_d        = last_q;
    load_done_d   = load_done_q;
    load_error_d  = load_error_q;
    cpu_reset_n_d = cpu_reset_n_q;
    case (state_q)
      ST_FETCH: begin
        last_d = fetch_last;
        if (word_end) begin
          mem_valid_d = 1'b1;
          // Running into the guard without the ROM's own end marker is an error.
          if (guard_hit && !rom_done) begin
            load_error_d = 1'b1;
          end
        end else begin
          rom_address_d = rom_address_q + 32'd1;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (!last_q) begin
            rom_address_d = rom_address_q + 32'd1;
            mem_addr_d    = mem_addr_q + ADDR_STEP;
          end
        end
      end
      default: ;
    endcase
    // Registered so both flags are high in the very first DONE cycle.
    if (state_d == ST_DONE) begin
      load_done_d   = 1'b1;
      cpu_reset_n_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_address_q <= '0;
      mem_valid_q   <= 1'b0;
      mem_addr_q    <= MEM_BASE;
      last_q        <= 1'b0;
      load_done_q   <= 1'b0;
      load_error_q  <= 1'b0;
      cpu_reset_n_q <= 1'b0;
    end else begin
      rom_address_q <= rom_address_d;
      mem_valid_q   <= mem_valid_d;
      mem_addr_q    <= mem_addr_d;
      last_q        <= last_d;
      load_done_q   <= load_done_d;
      load_error_q  <= load_error_d;
      cpu_reset_n_q <= cpu_reset_n_d;
    end
  end

  assign rom_address = rom_address_q;
  assign mem_valid   = mem_valid_q;
  assign mem_addr    = mem_addr_q;
  assign load_done   = load_done_q;
  assign load_error  = load_error_q;
  assign cpu_reset_n = cpu_reset_n_q;

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    int len;
    bit stall;
    int done_cyc;
  } scen_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] rst_v;
  logic [7:0] img28 [64];
  logic [7:0] img6  [8];
  int         len_a = 28;
  bit         stall_a = 1'b0;
  int         wcnt = 0;

  // Instance A: WORD_BYTES=4, base 0, default guard
  logic        ready_a;
  logic [31:0] rom_addr_a;
  logic [7:0]  rom_byte_a;
  logic        rom_done_a;
  logic        valid_a;
  logic [31:0] maddr_a;
  logic [31:0] wdata_a;
  logic [3:0]  be_a;
  logic        cpu_a, done_a, err_a;

  assign rom_byte_a = (len_a == 6) ? img6[rom_addr_a[2:0]] : img28[rom_addr_a[5:0]];
  assign rom_done_a = (rom_addr_a == 32'(len_a - 1));

  rom_loader #(.WORD_BYTES(4), .MEM_ADDR_WIDTH(32), .MEM_BASE(32'h0), .MAX_BYTES(65536)) dut_a (
    .clk(clk), .rst_n(rst_v[0]), .rom_address(rom_addr_a), .rom_byte(rom_byte_a),
    .rom_done(rom_done_a), .mem_valid(valid_a), .mem_ready(ready_a), .mem_addr(maddr_a),
    .mem_wdata(wdata_a), .mem_byte_en(be_a), .cpu_reset_n(cpu_a), .load_done(done_a),
    .load_error(err_a));

  // Instance B: guard at 8 bytes, rom_done never asserted
  logic [31:0] rom_addr_b;
  logic [7:0]  rom_byte_b;
  logic        valid_b;
  logic [31:0] maddr_b;
  logic [31:0] wdata_b;
  logic [3:0]  be_b;
  logic        cpu_b, done_b, err_b;

  assign rom_byte_b = rom_addr_b[7:0] + 8'h10;

  rom_loader #(.WORD_BYTES(4), .MEM_ADDR_WIDTH(32), .MEM_BASE(32'h0), .MAX_BYTES(8)) dut_b (
    .clk(clk), .rst_n(rst_v[1]), .rom_address(rom_addr_b), .rom_byte(rom_byte_b),
    .rom_done(1'b0), .mem_valid(valid_b), .mem_ready(1'b1), .mem_addr(maddr_b),
    .mem_wdata(wdata_b), .mem_byte_en(be_b), .cpu_reset_n(cpu_b), .load_done(done_b),
    .load_error(err_b));

  // Instance C: single-byte words at base 0x100
  logic [31:0] rom_addr_c;
  logic [7:0]  rom_byte_c;
  logic        rom_done_c;
  logic        valid_c;
  logic [31:0] maddr_c;
  logic [7:0]  wdata_c;
  logic [0:0]  be_c;
  logic        cpu_c, done_c, err_c;

  assign rom_byte_c = img28[rom_addr_c[5:0]];
  assign rom_done_c = (rom_addr_c == 32'd27);

  rom_loader #(.WORD_BYTES(1), .MEM_ADDR_WIDTH(32), .MEM_BASE(32'h100), .MAX_BYTES(65536)) dut_c (
    .clk(clk), .rst_n(rst_v[2]), .rom_address(rom_addr_c), .rom_byte(rom_byte_c),
    .rom_done(rom_done_c), .mem_valid(valid_c), .mem_ready(1'b1), .mem_addr(maddr_c),
    .mem_wdata(wdata_c), .mem_byte_en(be_c), .cpu_reset_n(cpu_c), .load_done(done_c),
    .load_error(err_c));

  logic [2:0] done_v;
  assign done_v = {done_c, done_b, done_a};

  function automatic wr_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    wr_t r;
    r.addr = a;
    r.data = d;
    r.be   = b;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  wr_t q_a[$];
  wr_t q_b[$];
  wr_t q_c[$];
  logic pend_a = 1'b0;
  wr_t  held_a;

  // Ready driver for A: optionally holds ready low for 3 cycles of every WRITE
  always @(posedge clk) begin
    #1;
    if (!stall_a) begin
      ready_a = 1'b1;
    end else if (valid_a) begin
      if (wcnt < 3) begin
        ready_a = 1'b0;
        wcnt++;
      end else begin
        ready_a = 1'b1;
      end
    end else begin
      ready_a = 1'b0;
      wcnt = 0;
    end
  end

  // Write monitor for A with stability check while stalled
  always @(negedge clk) begin
    if (!rst_v[0]) begin
      pend_a = 1'b0;
    end else begin
      if (pend_a) begin
        check("valid_held", 64'(valid_a), 64'd1);
        if (valid_a) begin
          check("addr_held", 64'(maddr_a), 64'(held_a.addr));
          check("data_held", 64'(wdata_a), 64'(held_a.data));
          check("be_held", 64'(be_a), 64'(held_a.be));
        end
      end
      if (valid_a && ready_a) begin
        q_a.push_back(mk(maddr_a, wdata_a, be_a));
        pend_a = 1'b0;
      end else if (valid_a) begin
        pend_a = 1'b1;
        held_a = mk(maddr_a, wdata_a, be_a);
      end else begin
        pend_a = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_v[1] && valid_b) q_b.push_back(mk(maddr_b, wdata_b, be_b));
    if (rst_v[2] && valid_c) q_c.push_back(mk(maddr_c, {24'h0, wdata_c}, {3'b0, be_c}));
  end

  task automatic cmp_writes(input string tag, input wr_t exp[$], input wr_t got[$]);
    check({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 64'(got[i].addr), 64'(exp[i].addr));
        check($sformatf("%s_data%0d", tag, i), 64'(got[i].data), 64'(exp[i].data));
        check($sformatf("%s_be%0d", tag, i), 64'(got[i].be), 64'(exp[i].be));
      end
    end
  endtask

  task automatic do_reset(input int k);
    @(posedge clk);
    #1;
    rst_v[k] = 1'b0;
    q_a.delete();
    q_b.delete();
    q_c.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_v[k] = 1'b1;
  endtask

  task automatic wait_done(input int k, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[k]) begin
        cyc = i;
        break;
      end
    end
  endtask

  wr_t   exp28[$];
  wr_t   exp6[$];
  wr_t   expb[$];
  wr_t   expc[$];
  scen_t scen[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit found;

    rst_v   = 3'b000;
    ready_a = 1'b1;
    for (int i = 0; i < 64; i++) img28[i] = 8'h00;
    img28[0] = 8'd14; img28[1] = 8'd20; img28[2]  = 8'd57; img28[6]  = 8'd1;
    img28[10] = 8'd5; img28[11] = 8'd1; img28[19] = 8'd13;
    img6[0] = 8'hAA; img6[1] = 8'hBB; img6[2] = 8'hCC; img6[3] = 8'hDD;
    img6[4] = 8'hEE; img6[5] = 8'hFF; img6[6] = 8'h00; img6[7] = 8'h00;

    exp28.push_back(mk(32'd0,  32'h0039140E, 4'hF));
    exp28.push_back(mk(32'd4,  32'h00010000, 4'hF));
    exp28.push_back(mk(32'd8,  32'h01050000, 4'hF));
    exp28.push_back(mk(32'd12, 32'h00000000, 4'hF));
    exp28.push_back(mk(32'd16, 32'h0D000000, 4'hF));
    exp28.push_back(mk(32'd20, 32'h00000000, 4'hF));
    exp28.push_back(mk(32'd24, 32'h00000000, 4'hF));
    exp6.push_back(mk(32'd0, 32'hDDCCBBAA, 4'hF));
    exp6.push_back(mk(32'd4, 32'h0000FFEE, 4'h3));
    expb.push_back(mk(32'd0, 32'h13121110, 4'hF));
    expb.push_back(mk(32'd4, 32'h17161514, 4'hF));
    for (int i = 0; i < 28; i++) expc.push_back(mk(32'h100 + 32'(i), {24'h0, img28[i]}, 4'h1));

    scen[0] = '{28, 1'b0, 35};
    scen[1] = '{28, 1'b1, 56};
    scen[2] = '{6,  1'b0, 8};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rom_address", 64'(rom_addr_a), 64'd0);
    check("rst_mem_valid", 64'(valid_a), 64'd0);
    check("rst_mem_addr", 64'(maddr_a), 64'd0);
    check("rst_mem_wdata", 64'(wdata_a), 64'd0);
    check("rst_mem_byte_en", 64'(be_a), 64'd0);
    check("rst_cpu_reset_n", 64'(cpu_a), 64'd0);
    check("rst_load_done", 64'(done_a), 64'd0);
    check("rst_load_error", 64'(err_a), 64'd0);
    check("rst_mem_addr_base", 64'(maddr_c), 64'h100);

    // Scenario table on instance A
    for (int s = 0; s < 3; s++) begin
      len_a   = scen[s].len;
      stall_a = scen[s].stall;
      do_reset(0);
      wait_done(0, 200, cyc);
      check($sformatf("s%0d_done_cycles", s), 64'(cyc), 64'(scen[s].done_cyc));
      check($sformatf("s%0d_cpu_reset_n", s), 64'(cpu_a), 64'd1);
      check($sformatf("s%0d_load_error", s), 64'(err_a), 64'd0);
      check($sformatf("s%0d_rom_addr_hold", s), 64'(rom_addr_a), 64'(scen[s].len - 1));
      repeat (3) @(negedge clk);
      check($sformatf("s%0d_done_sticky", s), 64'(done_a), 64'd1);
      if (scen[s].len == 6) cmp_writes($sformatf("s%0d", s), exp6, q_a);
      else cmp_writes($sformatf("s%0d", s), exp28, q_a);
    end

    // Reset asserted mid-load during the third WRITE, then a clean reload
    len_a   = 28;
    stall_a = 1'b0;
    do_reset(0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid_a && rom_addr_a == 32'd11) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_third_write_seen", 64'(found), 64'd1);
    #2;
    rst_v[0] = 1'b0;
    #1;
    check("mid_rom_address", 64'(rom_addr_a), 64'd0);
    check("mid_mem_valid", 64'(valid_a), 64'd0);
    check("mid_mem_addr", 64'(maddr_a), 64'd0);
    check("mid_mem_wdata", 64'(wdata_a), 64'd0);
    check("mid_mem_byte_en", 64'(be_a), 64'd0);
    check("mid_cpu_reset_n", 64'(cpu_a), 64'd0);
    check("mid_load_done", 64'(done_a), 64'd0);
    do_reset(0);
    wait_done(0, 200, cyc);
    check("reload_done_cycles", 64'(cyc), 64'd35);
    cmp_writes("reload", exp28, q_a);

    // Runaway guard on instance B
    do_reset(1);
    wait_done(1, 100, cyc);
    check("guard_done_cycles", 64'(cyc), 64'd10);
    check("guard_load_error", 64'(err_b), 64'd1);
    check("guard_cpu_reset_n", 64'(cpu_b), 64'd1);
    check("guard_rom_addr_hold", 64'(rom_addr_b), 64'd7);
    repeat (3) @(negedge clk);
    cmp_writes("guard", expb, q_b);

    // Single-byte words on instance C
    do_reset(2);
    wait_done(2, 200, cyc);
    check("wb1_done_cycles", 64'(cyc), 64'd56);
    check("wb1_cpu_reset_n", 64'(cpu_c), 64'd1);
    check("wb1_load_error", 64'(err_c), 64'd0);
    cmp_writes("wb1", expc, q_c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
